fp_div_arbiter: RTL and testbench

Round-robin arbiter that shares one `fp_divider` instance between `NUM_REQ` requesters. It accepts one division request at a time, sequences the divider through its start/valid/ready handshake, and returns the result and flags to the requester that issued it. It sits between the per-lane issue logic and the single divider, and only one operation is in flight at any time.

---
 rtl/fp_div_arbiter.sv | 170 +++++++++++++++++
 tb/tb_fp_div_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin front end that time-shares a single fp_divider
// between NUM_REQ requesters. One operation is in flight at a time; the
// owner's operands are latched at grant and its result is held until accepted.
module fp_div_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // Requester side
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_op_a,
    input  logic [32*NUM_REQ-1:0]  req_op_b,
    input  logic [NUM_REQ-1:0]     req_mode_fp,
    input  logic [NUM_REQ-1:0]     req_round_mode,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [31:0]            resp_result,
    output logic [4:0]             resp_flags,
    // Divider side
    output logic [31:0]            div_op_a,
    output logic [31:0]            div_op_b,
    output logic                   div_mode_fp,
    output logic                   div_round_mode,
    output logic                   div_start,
    input  logic                   div_ready_out,
    input  logic                   div_valid_out,
    output logic                   div_ready_in,
    input  logic [31:0]            div_result,
    input  logic [4:0]             div_flags,
    // Status
    output logic                   busy,
    output logic [IDX_W-1:0]       owner
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             mode_fp_q, mode_fp_d;
    logic             round_q, round_d;
    logic [31:0]      res_q, res_d;
    logic [4:0]       flags_q, flags_d;

    logic             grant_vld;
    logic [IDX_W-1:0] grant_idx;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_vld && req_valid[cand[IDX_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        mode_fp_d = mode_fp_q;
        round_d   = round_q;
        res_d     = res_q;
        flags_d   = flags_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    op_a_d    = req_op_a[32*grant_idx +: 32];
                    op_b_d    = req_op_b[32*grant_idx +: 32];
                    mode_fp_d = req_mode_fp[grant_idx];
                    round_d   = req_round_mode[grant_idx];
                    owner_d   = grant_idx;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                if (div_ready_out) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (div_valid_out) begin
                    res_d   = div_result;
                    flags_d = div_flags;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready[owner_q]) begin
                    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    owner_d  = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            mode_fp_q <= 1'b0;
            round_q   <= 1'b0;
            res_q     <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            mode_fp_q <= mode_fp_d;
            round_q   <= round_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready    = '0;
        resp_valid   = '0;
        div_start    = 1'b0;
        div_ready_in = 1'b0;
        unique case (state_q)
            // Gated by rst_n so nothing looks accepted while reset is held.
            StIdle:  if (grant_vld && rst_n) req_ready[grant_idx] = 1'b1;
            StIssue: div_start = 1'b1;
            StWait:  div_ready_in = 1'b1;
            StResp:  resp_valid[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign busy           = (state_q != StIdle);
    assign owner          = owner_q;
    assign div_op_a       = op_a_q;
    assign div_op_b       = op_b_q;
    assign div_mode_fp    = mode_fp_q;
    assign div_round_mode = round_q;
    assign resp_result    = res_q;
    assign resp_flags     = flags_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Self-checking bench for fp_div_arbiter with a behavioural divider model and
// a scoreboard of expected responses keyed by requester index.
module tb_fp_div_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_mode_fp, req_round_mode;
    logic [32*N-1:0] req_op_a, req_op_b;
    logic [N-1:0]    resp_valid, resp_ready;
    logic [31:0]     resp_result;
    logic [4:0]      resp_flags;
    logic [31:0]     div_op_a, div_op_b, div_result;
    logic            div_mode_fp, div_round_mode, div_start, div_ready_out;
    logic            div_valid_out, div_ready_in;
    logic [4:0]      div_flags;
    logic            busy;
    logic [1:0]      owner;

    always #5 clk = ~clk;

    fp_div_arbiter #(.NUM_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op_a      (req_op_a),
        .req_op_b      (req_op_b),
        .req_mode_fp   (req_mode_fp),
        .req_round_mode(req_round_mode),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_flags    (resp_flags),
        .div_op_a      (div_op_a),
        .div_op_b      (div_op_b),
        .div_mode_fp   (div_mode_fp),
        .div_round_mode(div_round_mode),
        .div_start     (div_start),
        .div_ready_out (div_ready_out),
        .div_valid_out (div_valid_out),
        .div_ready_in  (div_ready_in),
        .div_result    (div_result),
        .div_flags     (div_flags),
        .busy          (busy),
        .owner         (owner)
    );

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] res;
        logic [4:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];

    // Divider stand-in: known answers for the directed vectors, else a
    // scramble of operands and mode so misrouted inputs show up in the result.
    function automatic logic [36:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic mfp, input logic rm);
        if (a == 32'h40C0_0000 && b == 32'h4000_0000) return {5'h00, 32'h4040_0000};
        if (a == 32'h3F80_0000 && b == 32'h0000_0000) return {5'h08, 32'h7F80_0000};
        return {a[4:0] ^ b[4:0], a ^ {b[15:0], b[31:16]} ^ {mfp, rm, 30'h0}};
    endfunction

    // Behavioural divider: result valid D cycles after the start edge.
    int          model_d = 3;
    int          m_cnt;
    logic        m_busy;
    logic        dv_ready;
    assign div_ready_out = dv_ready;

    always @(posedge clk) begin
        if (!rst_n) begin
            div_valid_out <= 1'b0;
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            div_result    <= '0;
            div_flags     <= '0;
        end else if (div_start && div_ready_out) begin
            {div_flags, div_result} <= div_model(div_op_a, div_op_b, div_mode_fp, div_round_mode);
            if (model_d <= 1) begin
                div_valid_out <= 1'b1;
            end else begin
                m_cnt  <= model_d - 1;
                m_busy <= 1'b1;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                div_valid_out <= 1'b1;
                m_busy        <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end else if (div_valid_out && div_ready_in) begin
            div_valid_out <= 1'b0;
        end
    end

    // Scoreboard: pop and compare each accepted response.
    always @(negedge clk) begin
        int idx;
        int pos;
        idx = -1;
        pos = -1;
        if (rst_n && (resp_valid & resp_ready) != '0) begin
            for (int i = 0; i < N; i++) if (resp_valid[i]) idx = i;
            vectors++;
            if (!$onehot(resp_valid) || int'(owner) != idx) begin
                errors++;
                $display("FAIL resp_owner: resp_valid=%b owner=%0d, required one-hot matching owner",
                         resp_valid, owner);
            end
            for (int k = 0; k < sb_q.size(); k++) begin
                if (pos < 0 && int'(sb_q[k].idx) == idx) pos = k;
            end
            vectors++;
            if (pos < 0) begin
                errors++;
                $display("FAIL resp_unexpected: requester %0d result=%h, required no response",
                         idx, resp_result);
            end else begin
                if (resp_result !== sb_q[pos].res || resp_flags !== sb_q[pos].flags) begin
                    errors++;
                    $display("FAIL resp_data[%0d]: got %h/%h, required %h/%h", idx, resp_result,
                             resp_flags, sb_q[pos].res, sb_q[pos].flags);
                end
                sb_q.delete(pos);
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic mfp, input logic rm);
        exp_t e;
        req_op_a[32*i +: 32] = a;
        req_op_b[32*i +: 32] = b;
        req_mode_fp[i]       = mfp;
        req_round_mode[i]    = rm;
        req_valid[i]         = 1'b1;
        e.idx                = i[1:0];
        {e.flags, e.res}     = div_model(a, b, mfp, rm);
        sb_q.push_back(e);
    endtask

    // One clock: note grants before the edge, retire those requests after it.
    task automatic cycle();
        logic [N-1:0] g;
        @(negedge clk);
        g = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                req_valid[i] = 1'b0;
                grant_log.push_back(i);
            end
        end
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((req_valid != '0 || busy || sb_q.size() != 0) && n < max) begin
            cycle();
            n++;
        end
        vectors++;
        if (n >= max) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d busy=%b, required idle within %0d cycles",
                     sb_q.size(), busy, max);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        grant_log.delete();
    endtask

    task automatic test_reset();
        req_valid      = '0;
        resp_ready     = '1;
        req_op_a       = '0;
        req_op_b       = '0;
        req_mode_fp    = '0;
        req_round_mode = '0;
        dv_ready       = 1'b1;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({req_ready, resp_valid, div_start, div_ready_in, busy, owner, div_op_a, div_op_b,
             div_mode_fp, div_round_mode, resp_result, resp_flags} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b owner=%0d start=%b rdy_in=%b res=%h, required all 0",
                     busy, owner, div_start, div_ready_in, resp_result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat, starts, extra;
        logic [31:0] res_seen;
        logic [4:0]  flg_seen;
        lat = 0; starts = 0; extra = 0; res_seen = '0; flg_seen = '1;
        issue(1, 32'h40C0_0000, 32'h4000_0000, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b, required 0010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (div_start) starts++;
            if (req_ready != '0) extra++;
            if (resp_valid[1] && lat == 0) begin
                lat      = c;
                res_seen = resp_result;
                flg_seen = resp_flags;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (lat != 5) begin
            errors++;
            $display("FAIL single_latency: %0d cycles, required 5", lat);
        end
        vectors++;
        if (starts != 1 || extra != 0) begin
            errors++;
            $display("FAIL single_pulses: start=%0d extra_ready=%0d, required 1 and 0", starts, extra);
        end
        vectors++;
        if (res_seen !== 32'h4040_0000 || flg_seen !== 5'h00) begin
            errors++;
            $display("FAIL single_result: %h/%h, required 40400000/00", res_seen, flg_seen);
        end
        drain(20);
    endtask

    task automatic test_contention();
        int exp_a[3] = '{0, 2, 3};
        int exp_b[2] = '{0, 2};
        do_reset();
        issue(0, 32'h1111_0000, 32'h0000_2222, 1'b1, 1'b0);
        issue(2, 32'h3333_0000, 32'h0000_4444, 1'b0, 1'b1);
        issue(3, 32'h5555_0000, 32'h0000_6666, 1'b1, 1'b1);
        drain(100);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (grant_log.size() <= k || grant_log[k] != exp_a[k]) begin
                errors++;
                $display("FAIL contention_order[%0d]: got %0d, required %0d", k,
                         (grant_log.size() > k) ? grant_log[k] : -1, exp_a[k]);
            end
        end
        grant_log.delete();
        issue(2, 32'h7777_0000, 32'h0000_8888, 1'b1, 1'b0);
        issue(0, 32'h9999_0000, 32'h0000_AAAA, 1'b0, 1'b0);
        drain(100);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (grant_log.size() <= k || grant_log[k] != exp_b[k]) begin
                errors++;
                $display("FAIL rerequest_order[%0d]: got %0d, required %0d", k,
                         (grant_log.size() > k) ? grant_log[k] : -1, exp_b[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int exp_w[2] = '{3, 0};
        grant_log.delete();
        issue(0, 32'hAAAA_0001, 32'h0000_0003, 1'b1, 1'b0);
        issue(3, 32'hBBBB_0002, 32'h0000_0005, 1'b0, 1'b1);
        drain(100);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (grant_log.size() <= k || grant_log[k] != exp_w[k]) begin
                errors++;
                $display("FAIL wrap_order[%0d]: got %0d, required %0d", k,
                         (grant_log.size() > k) ? grant_log[k] : -1, exp_w[k]);
            end
        end
    endtask

    task automatic test_stall();
        dv_ready = 1'b0;
        issue(1, 32'hC0FF_EE01, 32'h1234_5678, 1'b1, 1'b1);
        cycle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (div_start !== 1'b1 || div_op_a !== 32'hC0FF_EE01 || div_op_b !== 32'h1234_5678 ||
                div_mode_fp !== 1'b1 || div_round_mode !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: start=%b a=%h b=%h, required 1 c0ffee01 12345678",
                         c, div_start, div_op_a, div_op_b);
            end
            @(posedge clk);
            #1;
        end
        dv_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (div_start !== 1'b0 || div_ready_in !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: start=%b ready_in=%b, required 0 and 1",
                     div_start, div_ready_in);
        end
        @(posedge clk);
        #1;
        drain(50);
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        resp_ready = '0;
        issue(2, 32'h3F80_0000, 32'h0000_0000, 1'b1, 1'b0);
        while (resp_valid == '0 && n < 20) begin
            cycle();
            n++;
        end
        for (int c = 0; c < 4; c++) begin
            resp_ready[0] = (c == 1);
            @(negedge clk);
            vectors++;
            if (resp_valid !== 4'b0100 || resp_result !== 32'h7F80_0000 || resp_flags !== 5'h08) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b res=%h flags=%h, required 0100 7f800000 08",
                         c, resp_valid, resp_result, resp_flags);
            end
            @(posedge clk);
            #1;
        end
        resp_ready = '1;
        drain(20);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        issue(1, 32'h4100_0000, 32'h4080_0000, 1'b1, 1'b0);
        while (!div_ready_in && n < 20) begin
            cycle();
            n++;
        end
        vectors++;
        if (!div_ready_in) begin
            errors++;
            $display("FAIL reach_wait: ready_in=%b, required 1", div_ready_in);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({req_ready, resp_valid, div_start, div_ready_in, busy, owner, div_op_a, div_op_b,
             div_mode_fp, div_round_mode, resp_result, resp_flags} !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%b owner=%0d rdy_in=%b a=%h, required all 0",
                     busy, owner, div_ready_in, div_op_a);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== '0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL dropped_resp[%0d]: valid=%b busy=%b, required 0 and 0",
                         c, resp_valid, busy);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_stall();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish before 200000");
        $fatal(1);
    end

endmodule
